// File: rtl/bram_ctrl_pkg.sv
// +----------------------------------------------------------------------------+
// | bram_ctrl_pkg                                                              |
// | Shared state encoding, default widths and round-robin pick helper.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package bram_ctrl_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_t;

  // last_gnt: 0 = m0 won most recently, 1 = m1 won most recently
  function automatic logic [1:0] rr_pick(input logic [1:0] req, input logic last_gnt);
    logic [1:0] pick;
    pick = req;
    if (req == 2'b11) begin
      pick = last_gnt ? 2'b01 : 2'b10;
    end
    return pick;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// +----------------------------------------------------------------------------+
// | rr_arb2                                                                    |
// | Two-way round-robin arbiter; combinational grant, pointer moves on grant.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rr_arb2
  import bram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt    = en ? rr_pick(req, last_q) : 2'b00;
    last_d = last_q;
    if (gnt[1]) begin
      last_d = 1'b1;
    end else if (gnt[0]) begin
      last_d = 1'b0;
    end
  end

  // Reset pretends m1 won last so m0 is favoured first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | bram_rr_arbiter                                                            |
// | Two-requester round-robin front end for a simple dual-port BRAM with      |
// | optional zero-fill after reset or on clear.                                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module bram_rr_arbiter
  import bram_ctrl_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter bit INIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_wen_A,
  output logic [ADDR_W-1:0] ram_addr_A,
  output logic [DATA_W-1:0] ram_din_A,
  output logic              ram_ren_B,
  output logic [ADDR_W-1:0] ram_addr_B,
  input  logic [DATA_W-1:0] ram_dout_B,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic              init_done_q;

  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (arb_en),
    .req   ({m1_req, m0_req}),
    .gnt   (arb_gnt)
  );

  always_comb begin : p_winner
    win_we    = m0_we;
    win_addr  = m0_addr;
    win_wdata = m0_wdata;
    if (arb_gnt[1]) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  always_comb begin : p_fsm
    state_d    = state_q;
    cnt_d      = cnt_q;
    arb_en     = 1'b0;
    ram_wen_A  = 1'b0;
    ram_addr_A = '0;
    ram_din_A  = '0;
    ram_ren_B  = 1'b0;
    ram_addr_B = '0;
    case (state_q)
      IDLE: begin
        state_d = INIT_EN ? INIT : RUN;
      end
      INIT: begin
        ram_wen_A  = 1'b1;
        ram_addr_A = cnt_q;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == ADDR_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (clr) begin
          state_d = INIT;
          cnt_d   = '0;
        end else begin
          arb_en = 1'b1;
          if (|arb_gnt) begin
            if (win_we) begin
              ram_wen_A  = 1'b1;
              ram_addr_A = win_addr;
              ram_din_A  = win_wdata;
            end else begin
              ram_ren_B  = 1'b1;
              ram_addr_B = win_addr;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grants are zero whenever arbitration is disabled, so this is empty outside RUN.
  assign rvalid_d = arb_gnt & {~m1_we, ~m0_we};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rvalid_q    <= 2'b00;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rvalid_q    <= rvalid_d;
      init_done_q <= (state_d == RUN);
    end
  end

  assign m0_gnt    = arb_gnt[0];
  assign m1_gnt    = arb_gnt[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  // Read data is the raw RAM port, blanked in IDLE so nothing leaks out during reset.
  assign m0_rdata  = (state_q != IDLE) ? ram_dout_B : '0;
  assign m1_rdata  = (state_q != IDLE) ? ram_dout_B : '0;
  assign init_done = init_done_q;

endmodule

`default_nettype wire

// File: tb/tb_bram_rr_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_bram_rr_arbiter                                                         |
// | Randomized bench with a transaction-level reference model and BRAM model. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_bram_rr_arbiter;

  localparam int AW    = 10;
  localparam int DW    = 18;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_wen_A, ram_ren_B, init_done;
  logic [AW-1:0] ram_addr_A, ram_addr_B;
  logic [DW-1:0] ram_din_A;
  logic [DW-1:0] ram_dout_B;

  always #5 clk = ~clk;

  bram_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .INIT_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wen_A(ram_wen_A), .ram_addr_A(ram_addr_A), .ram_din_A(ram_din_A),
    .ram_ren_B(ram_ren_B), .ram_addr_B(ram_addr_B), .ram_dout_B(ram_dout_B),
    .init_done(init_done)
  );

  // Behavioural BRAM, preloaded with non-zero garbage so the zero-fill is observable.
  logic [DW-1:0] ram [DEPTH];
  logic          ram_ready = 1'b0;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= DW'(i * 37 + 5);
      ram_ready <= 1'b1;
    end else begin
      if (ram_wen_A) ram[ram_addr_A] <= ram_din_A;
      if (ram_ren_B) ram_dout_B <= ram_wen_A ? ram_din_A : ram[ram_addr_B];
    end
  end

  // Reference model: phase 0=idle, 1=zero-fill, 2=run
  int            total = 0;
  int            bad = 0;
  int            ph = 0;
  int            icnt = 0;
  logic          last_g = 1'b1;
  logic [1:0]    exp_rv = 2'b00;
  logic [DW-1:0] exp_rd [2];
  logic [DW-1:0] exp_mem [DEPTH];
  logic [1:0]    gprev = 2'b00;

  logic          cur_r0 = 1'b0, cur_w0 = 1'b0, cur_r1 = 1'b0, cur_w1 = 1'b0;
  logic [AW-1:0] cur_a0 = '0, cur_a1 = '0;
  logic [DW-1:0] cur_d0 = '0, cur_d1 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
    chk({tag, "_rv"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    chk({tag, "_rd0"}, {14'd0, m0_rdata}, 32'd0);
    chk({tag, "_rd1"}, {14'd0, m1_rdata}, 32'd0);
    chk({tag, "_wen"}, {31'd0, ram_wen_A}, 32'd0);
    chk({tag, "_addrA"}, {22'd0, ram_addr_A}, 32'd0);
    chk({tag, "_din"}, {14'd0, ram_din_A}, 32'd0);
    chk({tag, "_ren"}, {31'd0, ram_ren_B}, 32'd0);
    chk({tag, "_addrB"}, {22'd0, ram_addr_B}, 32'd0);
    chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
  endtask

  task automatic eval();
    logic [1:0]    eg;
    logic [1:0]    nrv;
    logic          idx, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    eg  = 2'b00;
    nrv = 2'b00;
    chk("excl", {31'd0, ram_wen_A & ram_ren_B}, 32'd0);
    chk("rv0", {31'd0, m0_rvalid}, {31'd0, exp_rv[0]});
    chk("rv1", {31'd0, m1_rvalid}, {31'd0, exp_rv[1]});
    if (exp_rv[0]) chk("rd0", {14'd0, m0_rdata}, {14'd0, exp_rd[0]});
    if (exp_rv[1]) chk("rd1", {14'd0, m1_rdata}, {14'd0, exp_rd[1]});
    case (ph)
      0: begin
        chk_all_zero("idle");
        ph   = 1;
        icnt = 0;
      end
      1: begin
        chk("init_wen", {31'd0, ram_wen_A}, 32'd1);
        chk("init_addr", {22'd0, ram_addr_A}, 32'(icnt));
        chk("init_din", {14'd0, ram_din_A}, 32'd0);
        chk("init_ren", {31'd0, ram_ren_B}, 32'd0);
        chk("init_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd0);
        chk("init_done_lo", {31'd0, init_done}, 32'd0);
        exp_mem[icnt] = '0;
        if (icnt == DEPTH - 1) ph = 2;
        icnt++;
      end
      default: begin
        chk("run_done", {31'd0, init_done}, 32'd1);
        if (clr) begin
          ph   = 1;
          icnt = 0;
        end else if (m0_req && m1_req) begin
          // both waiting: the one that did not win most recently goes
          eg = (last_g == 1'b1) ? 2'b01 : 2'b10;
        end else begin
          eg = {m1_req, m0_req};
        end
        chk("gnt", {30'd0, m1_gnt, m0_gnt}, {30'd0, eg});
        if (eg != 2'b00) begin
          idx    = eg[1];
          we     = idx ? m1_we : m0_we;
          a      = idx ? m1_addr : m0_addr;
          d      = idx ? m1_wdata : m0_wdata;
          last_g = idx;
          if (we) begin
            chk("wr_wen", {31'd0, ram_wen_A}, 32'd1);
            chk("wr_addr", {22'd0, ram_addr_A}, {22'd0, a});
            chk("wr_din", {14'd0, ram_din_A}, {14'd0, d});
            exp_mem[a] = d;
          end else begin
            chk("rd_ren", {31'd0, ram_ren_B}, 32'd1);
            chk("rd_addr", {22'd0, ram_addr_B}, {22'd0, a});
            chk("rd_wen", {31'd0, ram_wen_A}, 32'd0);
            nrv[idx]    = 1'b1;
            exp_rd[idx] = exp_mem[a];
          end
        end else begin
          chk("nop_wen", {31'd0, ram_wen_A}, 32'd0);
          chk("nop_ren", {31'd0, ram_ren_B}, 32'd0);
        end
      end
    endcase
    exp_rv = nrv;
    gprev  = eg;
  endtask

  task automatic apply(input logic r0, input logic w0, input logic [AW-1:0] a0,
                       input logic [DW-1:0] d0, input logic r1, input logic w1,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1, input logic c);
    @(posedge clk);
    #1;
    m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = d1;
    clr = c;
    #3;
    eval();
  endtask

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, DEPTH - 1));
    return AW'($urandom_range(0, 15));
  endfunction

  // New requests only once the previous one was granted or none was pending.
  task automatic rand_tick(input logic c, input logic force0);
    if (!cur_r0 || gprev[0]) begin
      cur_r0 = ($urandom_range(0, 3) != 0) || force0;
      cur_w0 = 1'($urandom_range(0, 1));
      cur_a0 = rand_addr();
      cur_d0 = DW'($urandom);
    end
    if (!cur_r1 || gprev[1]) begin
      cur_r1 = ($urandom_range(0, 3) != 0);
      cur_w1 = 1'($urandom_range(0, 1));
      cur_a1 = rand_addr();
      cur_d1 = DW'($urandom);
    end
    apply(cur_r0, cur_w0, cur_a0, cur_d0, cur_r1, cur_w1, cur_a1, cur_d1, c);
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #3;
    eval();
  endtask

  initial begin
    // power-on reset with requests asserted
    m0_req = 1'b1; m1_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    m0_req = 1'b0; m1_req = 1'b0;
    release_reset();
    repeat (DEPTH) rand_tick(1'b0, 1'b0);

    // directed: write/read-back, same-address conflict, addr 512, alternation
    apply(1, 1, 10'd5, 18'h2A5A5, 0, 0, 10'd0, 18'h0, 0);
    apply(1, 0, 10'd5, 18'h0, 0, 0, 10'd0, 18'h0, 0);
    apply(0, 0, 10'd0, 18'h0, 1, 1, 10'd3, 18'h00011, 0);
    apply(1, 1, 10'd3, 18'h3FFFF, 1, 0, 10'd3, 18'h0, 0);
    apply(0, 0, 10'd0, 18'h0, 1, 0, 10'd3, 18'h0, 0);
    apply(1, 0, 10'd512, 18'h0, 0, 0, 10'd0, 18'h0, 0);
    repeat (6) apply(1, 0, 10'd1, 18'h0, 1, 0, 10'd2, 18'h0, 0);
    apply(0, 0, 10'd0, 18'h0, 0, 0, 10'd0, 18'h0, 0);
    cur_r0 = 1'b0; cur_r1 = 1'b0; gprev = 2'b00;

    repeat (600) rand_tick(1'b0, 1'b0);
    // clear with m0 pending, then full refill
    rand_tick(1'b1, 1'b1);
    repeat (DEPTH) rand_tick(1'b0, 1'b0);
    repeat (300) rand_tick(1'b0, 1'b0);

    // clear again, then reset at fill address 300
    rand_tick(1'b1, 1'b0);
    repeat (301) rand_tick(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (2) begin
      @(posedge clk);
      #1;
      chk_all_zero("rst_hold");
    end
    ph = 0; exp_rv = 2'b00; last_g = 1'b1; gprev = 2'b00;
    release_reset();
    repeat (DEPTH) rand_tick(1'b0, 1'b0);
    repeat (200) rand_tick(1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
